// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the round-robin demux sequencer.
// Rev 1.0
`default_nettype none

package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/next_ch_pick.sv
// next_ch_pick: finds the next higher enabled channel above cur_i and the lowest enabled channel.
// Rev 1.0
`default_nettype none

module next_ch_pick
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    output logic [SEL_W-1:0]  next_o,
    output logic [SEL_W-1:0]  low_o,
    output logic              wrap_o
);

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        next_o = cur_i;
        low_o  = '0;
        wrap_o = 1'b1;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_i[k]) begin
                low_o = SEL_W'(k);
                if (k > int'(cur_i)) begin
                    next_o = SEL_W'(k);
                    wrap_o = 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_rr_sequencer.sv
// demux_rr_sequencer: round-robin scheduler driving a 1:4 demux with per-channel dwell and
// a break-before-make gap. Rev 1.0
`default_nettype none

module demux_rr_sequencer
    import demux_pkg::*;
#(
    parameter int DWELL_W    = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               data_in,
    output logic               In,
    output logic               S0,
    output logic               S1,
    output logic               busy,
    output logic               ch_valid,
    output logic               frame_done,
    output logic               err_cfg
);

    localparam int GAP_W = 4;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_CH-1:0]   en_q, en_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                stop_pend_q, stop_pend_d;
    logic                fd_q, fd_d;
    logic                err_q, err_d;

    logic [NUM_CH-1:0]   w_pick_mask;
    logic [SEL_W-1:0]    w_next, w_low;
    logic                w_wrap;

    // While idle the finder looks at the live mask so start can pick the first channel.
    assign w_pick_mask = (state_q == IDLE) ? ch_en : en_q;

    next_ch_pick u_pick (
        .mask_i (w_pick_mask),
        .cur_i  (sel_q),
        .next_o (w_next),
        .low_o  (w_low),
        .wrap_o (w_wrap)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        en_d        = en_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        stop_pend_d = stop_pend_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((ch_en != '0) && (dwell != '0)) begin
                        en_d        = ch_en;
                        dwell_d     = dwell;
                        sel_d       = w_low;
                        stop_pend_d = 1'b0;
                        gap_d       = GAP_W'(1);
                        state_d     = GAP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (stop) stop_pend_d = 1'b1;
                if (gap_q == GAP_W'(GAP_CYCLES)) begin
                    gap_d   = '0;
                    cnt_d   = DWELL_W'(1);
                    state_d = DWELL;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            DWELL: begin
                if (stop) stop_pend_d = 1'b1;
                if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (!w_wrap) begin
                        sel_d   = w_next;
                        gap_d   = GAP_W'(1);
                        state_d = GAP;
                    end else if (stop_pend_q || stop) begin
                        sel_d       = '0;
                        stop_pend_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        sel_d   = w_low;
                        gap_d   = GAP_W'(1);
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered pulse: flag the coming cycle if it is the last dwell cycle of the top channel.
        fd_d = (state_d == DWELL) && (cnt_d == dwell_q) && w_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            en_q        <= '0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            stop_pend_q <= 1'b0;
            fd_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            stop_pend_q <= stop_pend_d;
            fd_q        <= fd_d;
            err_q       <= err_d;
        end
    end

    assign In         = data_in & (state_q == DWELL);
    assign S1         = sel_q[1];
    assign S0         = sel_q[0];
    assign busy       = (state_q != IDLE);
    assign ch_valid   = (state_q == DWELL);
    assign frame_done = fd_q;
    assign err_cfg    = err_q;

endmodule

`default_nettype wire
